// File: rtl/fir3_output_serializer.sv
// Back end of the 3-parallel FIR: rounds/saturates each 3-sample block on entry,
// buffers blocks in a small FIFO and serialises the samples onto a valid/ready stream.
module fir3_output_serializer #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 32,
    parameter int SHIFT = 31,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       blk_valid,
    input  logic [IN_W-1:0]            y0,
    input  logic [IN_W-1:0]            y1,
    input  logic [IN_W-1:0]            y2,
    output logic                       blk_ready,
    output logic                       s_valid,
    input  logic                       s_ready,
    output logic [OUT_W-1:0]           s_data,
    output logic                       s_sat,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = OUT_W + 1;

    // Saturation bounds sign-extended to the widened rounding width.
    localparam logic signed [IN_W:0] MAX_EXT = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_EXT = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [OUT_W-1:0]     MAX_OUT = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]     MIN_OUT = {1'b1, {(OUT_W - 1){1'b0}}};

    logic [IN_W-1:0]    y_in [3];
    logic [ENT_W-1:0]   conv [3];
    logic [3*ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [1:0]       phase_reg;
    logic             overflow_reg;

    logic             wr_en;
    logic             xfer;
    logic             pop;
    logic [3*ENT_W-1:0] head;
    logic [ENT_W-1:0]   head_sample;

    assign y_in[0] = y0;
    assign y_in[1] = y1;
    assign y_in[2] = y2;

    // Each entry is {sat, value}; conversion happens once, at write time.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_conv
            logic signed [IN_W:0] y_ext;
            logic signed [IN_W:0] r;
            assign y_ext = $signed({y_in[gi][IN_W-1], y_in[gi]});
            if (SHIFT == 0) begin : g_nornd
                assign r = y_ext;
            end else begin : g_rnd
                localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
                localparam logic signed [IN_W:0] RND = (IN_W + 1)'(1) <<< RSH;
                assign r = (y_ext + RND) >>> SHIFT;
            end
            assign conv[gi] = (r > MAX_EXT) ? {1'b1, MAX_OUT} :
                              (r < MIN_EXT) ? {1'b1, MIN_OUT} :
                                              {1'b0, r[OUT_W-1:0]};
        end
    endgenerate

    assign blk_ready = (level_reg < LVL_W'(DEPTH));
    assign s_valid   = (level_reg != '0);
    assign wr_en     = blk_valid && blk_ready;
    assign xfer      = s_valid && s_ready;
    assign pop       = xfer && (phase_reg == 2'd2);

    // Storage is not reset; s_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {conv[2], conv[1], conv[0]};
        end
    end

    assign head = mem[rd_ptr_reg];

    always_comb begin
        head_sample = head[ENT_W-1:0];
        case (phase_reg)
            2'd1:    head_sample = head[2*ENT_W-1:ENT_W];
            2'd2:    head_sample = head[3*ENT_W-1:2*ENT_W];
            default: head_sample = head[ENT_W-1:0];
        endcase
    end

    assign s_data   = s_valid ? head_sample[OUT_W-1:0] : '0;
    assign s_sat    = s_valid ? head_sample[OUT_W] : 1'b0;
    assign level    = level_reg;
    assign overflow = overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            phase_reg    <= 2'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (blk_valid && !blk_ready) begin
                overflow_reg <= 1'b1;
            end
            if (xfer) begin
                phase_reg <= (phase_reg == 2'd2) ? 2'd0 : phase_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // A same-cycle write and pop leave the occupancy unchanged.
            case ({wr_en, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_fir3_output_serializer.sv
// Directed bench for fir3_output_serializer: conversion corners, backpressure/overflow,
// simultaneous write+pop, pointer wrap and mid-block reset.
module tb_fir3_output_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        blk_valid;
    logic [63:0] y0, y1, y2;
    logic        blk_ready;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_sat;
    logic [2:0]  level;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    // Expected samples in emission order, plus expected occupancy/phase/sticky flag.
    logic [32:0] q[$];
    int          lvl_m;
    int          ph_m;
    logic        ovf_m;

    fir3_output_serializer #(.IN_W(64), .OUT_W(32), .SHIFT(31), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .y0(y0), .y1(y1), .y2(y2),
        .blk_ready(blk_ready), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sat(s_sat), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, apply inputs, advance the model.
    task automatic tick(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [32:0] ea, input logic [32:0] eb,
                        input logic [32:0] ec, input logic rdy);
        logic accept;
        logic xfer;
        blk_valid = v;
        y0 = a;
        y1 = b;
        y2 = c;
        s_ready = rdy;
        chk("s_valid", 64'(s_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk("sample", 64'({s_sat, s_data}), 64'(q[0]));
        chk("blk_ready", 64'(blk_ready), 64'(lvl_m < 4));
        chk("level", 64'(level), 64'(lvl_m));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        accept = v && (lvl_m < 4);
        xfer   = (q.size() != 0) && rdy;
        if (v && !accept) ovf_m = 1'b1;
        step();
        blk_valid = 1'b0;
        if (xfer) begin
            void'(q.pop_front());
            if (ph_m == 2) begin
                ph_m = 0;
                lvl_m--;
            end else begin
                ph_m++;
            end
        end
        if (accept) begin
            q.push_back(ea);
            q.push_back(eb);
            q.push_back(ec);
            lvl_m++;
        end
    endtask

    task automatic idle(input logic rdy);
        tick(1'b0, 64'd0, 64'd0, 64'd0, 33'd0, 33'd0, 33'd0, rdy);
    endtask

    // Block whose samples are k, k+1, k+2 in output units (exact, no rounding residue).
    task automatic blk(input int k, input logic rdy);
        tick(1'b1, 64'(k) << 31, 64'(k + 1) << 31, 64'(k + 2) << 31,
             {1'b0, 32'(k)}, {1'b0, 32'(k + 1)}, {1'b0, 32'(k + 2)}, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        blk_valid = 1'b0;
        step();
        rst = 1'b0;
        q.delete();
        lvl_m = 0;
        ph_m  = 0;
        ovf_m = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        blk_valid = 1'b0;
        s_ready = 1'b0;
        y0 = '0;
        y1 = '0;
        y2 = '0;
        step();
        do_reset();
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_blk_ready", 64'(blk_ready), 64'd1);
        chk("rst_s_data", 64'(s_data), 64'd0);
        chk("rst_s_sat", 64'(s_sat), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Positive rounding: 2^31 -> 1, 2^30 -> 1 (half up), 2^30-1 -> 0.
        tick(1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_3FFF_FFFF,
             {1'b0, 32'd1}, {1'b0, 32'd1}, {1'b0, 32'd0}, 1'b1);
        chk("first_valid", 64'(s_valid), 64'd1);
        chk("first_y0", 64'(s_data), 64'd1);
        repeat (4) idle(1'b1);

        // Negative rounding: -2^30 -> 0, -2^30-1 -> -1, -2^31 -> -1.
        tick(1'b1, 64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_BFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
             {1'b0, 32'h0}, {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'hFFFF_FFFF}, 1'b1);
        repeat (4) idle(1'b1);

        // Saturation both ways, then an exact zero.
        tick(1'b1, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0,
             {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000}, {1'b0, 32'h0}, 1'b1);
        repeat (4) idle(1'b1);

        // Fill under backpressure: 4 accepted, 5th dropped, head stays put.
        for (int b = 0; b < 5; b++) blk(100 + 10 * b, 1'b0);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_overflow", 64'(overflow), 64'd1);
        chk("fill_blk_ready", 64'(blk_ready), 64'd0);
        repeat (3) idle(1'b0);
        chk("stall_data", 64'(s_data), 64'd100);
        repeat (3) idle(1'b1);
        chk("after_pop_ready", 64'(blk_ready), 64'd1);
        repeat (10) idle(1'b1);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Write and pop in the same cycle at level 2.
        blk(200, 1'b0);
        blk(210, 1'b0);
        idle(1'b1);
        idle(1'b1);
        blk(220, 1'b1);
        chk("wr_pop_level", 64'(level), 64'd2);
        repeat (7) idle(1'b1);

        // Sustained traffic across several pointer wraps.
        for (int b = 0; b < 10; b++) begin
            blk(300 + 10 * b, 1'b1);
            idle(1'b1);
            idle(1'b1);
        end
        repeat (3) idle(1'b1);

        // Reset while mid-block (phase 1, level 3).
        for (int b = 0; b < 3; b++) blk(400 + 10 * b, 1'b0);
        idle(1'b1);
        chk("pre_rst_level", 64'(level), 64'd3);
        blk(430, 1'b0);
        blk(440, 1'b0);
        chk("pre_rst_overflow", 64'(overflow), 64'd1);
        do_reset();
        chk("mid_rst_s_valid", 64'(s_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        blk(500, 1'b1);
        chk("post_rst_y0", 64'(s_data), 64'd500);
        repeat (4) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
